// File: rtl/seg7_scan_to_bcd.sv
// Recovers BCD digits from a multiplexed 7-segment drive: samples, filters, decodes and frames NDIG digits.
// Optional SEG7_ERRCNT_EN adds err_count_o, a saturating count of illegal digits accepted.
module seg7_scan_to_bcd #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [6:0]        seg_i,
  input  logic [NDIG-1:0]   dig_en_i,
  output logic [4*NDIG-1:0] bcd_out_o,
  output logic [NDIG-1:0]   digit_err_o,
  output logic              frame_valid_o,
  input  logic              frame_ready_i,
`ifdef SEG7_ERRCNT_EN
  output logic [7:0]        err_count_o,
`endif
  output logic              overrun_o
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  typedef enum logic {COLLECT, PRESENT} state_e;

  state_e                 state_q;
  logic [6:0]             seg_q;
  logic [NDIG-1:0]        en_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [NDIG-1:0][3:0]   shd_bcd_q, shd_bcd_d, bcd_q;
  logic [NDIG-1:0]        shd_err_q, shd_err_d, err_q;
  logic [NDIG-1:0]        seen_q, seen_all;
  logic                   fv_q, ov_q;
  logic                   onehot_in, accept, complete, hs;
  logic [3:0]             dec_nib;
  logic                   dec_err;

  assign onehot_in = (dig_en_i != '0) && ((dig_en_i & (dig_en_i - NDIG'(1))) == '0);

  // cnt_q = number of consecutive edges the current sample has been registered unchanged
  always_comb begin
    cnt_d = '0;
    if (onehot_in) begin
      if ({seg_i, dig_en_i} == {seg_q, en_q})
        cnt_d = (cnt_q == CW'(STABLE_CYC)) ? cnt_q : cnt_q + CW'(1);
      else
        cnt_d = CW'(1);
    end
  end

  assign accept = (cnt_q == CW'(STABLE_CYC)) && !done_q;
  assign done_d = (cnt_d == CW'(STABLE_CYC)) && (done_q || accept);

  always_comb begin
    dec_nib = 4'hE;
    dec_err = 1'b1;
    case (seg_q)
      7'b1111110: begin dec_nib = 4'h0; dec_err = 1'b0; end
      7'b0110000: begin dec_nib = 4'h1; dec_err = 1'b0; end
      7'b1101101: begin dec_nib = 4'h2; dec_err = 1'b0; end
      7'b1111001: begin dec_nib = 4'h3; dec_err = 1'b0; end
      7'b0110011: begin dec_nib = 4'h4; dec_err = 1'b0; end
      7'b1011011: begin dec_nib = 4'h5; dec_err = 1'b0; end
      7'b1011111: begin dec_nib = 4'h6; dec_err = 1'b0; end
      7'b1110000: begin dec_nib = 4'h7; dec_err = 1'b0; end
      7'b1111111: begin dec_nib = 4'h8; dec_err = 1'b0; end
      7'b1111011: begin dec_nib = 4'h9; dec_err = 1'b0; end
      7'b0000000: begin dec_nib = 4'hF; dec_err = 1'b0; end
      default:    begin dec_nib = 4'hE; dec_err = 1'b1; end
    endcase
  end

  always_comb begin
    shd_bcd_d = shd_bcd_q;
    shd_err_d = shd_err_q;
    for (int i = 0; i < NDIG; i++) begin
      if (accept && en_q[i]) begin
        shd_bcd_d[i] = dec_nib;
        shd_err_d[i] = dec_err;
      end
    end
  end

  assign seen_all = seen_q | (accept ? en_q : '0);
  assign complete = accept && (&seen_all);
  assign hs       = fv_q && frame_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= COLLECT;
      seg_q     <= '0;
      en_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      shd_bcd_q <= '0;
      shd_err_q <= '0;
      seen_q    <= '0;
      bcd_q     <= '0;
      err_q     <= '0;
      fv_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      seg_q     <= seg_i;
      en_q      <= dig_en_i;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      shd_bcd_q <= shd_bcd_d;
      shd_err_q <= shd_err_d;
      seen_q    <= complete ? '0 : seen_all;
      if (complete) begin
        // a frame landing on an unaccepted one flags overrun; a same-edge handshake does not
        bcd_q   <= shd_bcd_d;
        err_q   <= shd_err_d;
        fv_q    <= 1'b1;
        ov_q    <= fv_q && !frame_ready_i;
        state_q <= PRESENT;
      end else if (hs) begin
        fv_q    <= 1'b0;
        ov_q    <= 1'b0;
        state_q <= COLLECT;
      end
    end
  end

`ifdef SEG7_ERRCNT_EN
  logic [7:0] ecnt_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                 ecnt_q <= '0;
    else if (hs)                                  ecnt_q <= '0;
    else if (accept && dec_err && ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
  end
  assign err_count_o = ecnt_q;
`endif

  assign bcd_out_o     = bcd_q;
  assign digit_err_o   = err_q;
  assign frame_valid_o = fv_q;
  assign overrun_o     = ov_q;

endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
// Randomized plus directed bench for seg7_scan_to_bcd against a sample-history reference model.
module tb_seg7_scan_to_bcd;
  localparam int NDIG = 4;
  localparam int S    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [6:0]        seg = '0;
  logic [NDIG-1:0]   en = '0;
  logic              ready = 1'b0;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   digit_err;
  logic              frame_valid, overrun;
`ifdef SEG7_ERRCNT_EN
  logic [7:0]        err_count;
`endif

  seg7_scan_to_bcd #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .seg_i(seg), .dig_en_i(en),
    .bcd_out_o(bcd_out), .digit_err_o(digit_err), .frame_valid_o(frame_valid),
    .frame_ready_i(ready),
`ifdef SEG7_ERRCNT_EN
    .err_count_o(err_count),
`endif
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: history of registered samples, newest first
  logic [10:0]     hq[$];
  logic [3:0]      m_shd [NDIG];
  logic [NDIG-1:0] m_shd_err, m_seen, m_err;
  logic [15:0]     m_bcd;
  logic            m_fv, m_ov;
  int              m_ec;

  function automatic void mdecode(input logic [6:0] s, output logic [3:0] n, output logic e);
    n = 4'hE; e = 1'b1;
    if (s == 7'b0) begin n = 4'hF; e = 1'b0; end
    for (int k = 0; k < 10; k++) if (s == pat[k]) begin n = 4'(k); e = 1'b0; end
  endfunction

  task automatic model_reset();
    hq = {};
    for (int j = 0; j <= S; j++) hq.push_back(11'd0);
    for (int j = 0; j < NDIG; j++) m_shd[j] = 4'h0;
    m_shd_err = '0; m_seen = '0; m_err = '0; m_bcd = '0;
    m_fv = 1'b0; m_ov = 1'b0; m_ec = 0;
  endtask

  task automatic model_step();
    logic acc, hs, e;
    logic [3:0] n, en0;
    if (!rst_n) begin model_reset(); return; end
    en0 = hq[0][3:0];
    acc = ($countones(en0) == 1) && (hq[S] != hq[0]);
    for (int j = 1; j < S; j++) if (hq[j] != hq[0]) acc = 1'b0;
    hs = m_fv && ready;
    mdecode(hq[0][10:4], n, e);
    if (acc) begin
      for (int j = 0; j < NDIG; j++) if (en0[j]) begin
        m_shd[j] = n; m_shd_err[j] = e; m_seen[j] = 1'b1;
      end
    end
    if (acc && m_seen == '1) begin
      for (int j = 0; j < NDIG; j++) m_bcd[4*j +: 4] = m_shd[j];
      m_err  = m_shd_err;
      m_ov   = m_fv && !ready;
      m_fv   = 1'b1;
      m_seen = '0;
    end else if (hs) begin
      m_fv = 1'b0; m_ov = 1'b0;
    end
    if (hs) m_ec = 0;
    else if (acc && e && m_ec < 255) m_ec++;
    hq.push_front({seg, en});
    void'(hq.pop_back());
  endtask

  task automatic compare_all();
    check("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check("digit_err", 32'(digit_err), 32'(m_err));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("overrun", 32'(overrun), 32'(m_ov));
`ifdef SEG7_ERRCNT_EN
    check("err_count", 32'(err_count), 32'(m_ec));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [6:0] s, input logic [NDIG-1:0] e, input int n);
    seg = s; en = e;
    repeat (n) tick();
  endtask

  task automatic scan(input int d3, input int d2, input int d1, input int d0);
    drive(pat[d0], 4'b0001, 6); drive(7'b0, 4'b0000, 1);
    drive(pat[d1], 4'b0010, 6); drive(7'b0, 4'b0000, 1);
    drive(pat[d2], 4'b0100, 6); drive(7'b0, 4'b0000, 1);
    drive(pat[d3], 4'b1000, 6); drive(7'b0, 4'b0000, 1);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    tick(); tick();
    rst_n = 1'b1;

    // basic scan 3,0,2,9
    ready = 1'b1;
    scan(9, 2, 0, 3);
    check("scan_9203", 32'(bcd_out), 32'h9203);

    // short hold, then 7 on digit 1; ghost enable in between
    drive(pat[0], 4'b0001, 6); drive(7'b0, 4'b0, 1);
    drive(pat[3], 4'b0010, 3); drive(pat[7], 4'b0010, 6);
    drive(pat[8], 4'b0011, 2); drive(7'b0, 4'b0, 1);
    drive(pat[5], 4'b0100, 6); drive(7'b0, 4'b0, 1);
    drive(pat[1], 4'b1000, 6); drive(7'b0, 4'b0, 1);
    check("slot1_seven", 32'(bcd_out), 32'h1570);

    // illegal on digit 2, blank on digit 0
    drive(7'b0000000, 4'b0001, 6); drive(7'b0, 4'b0, 1);
    drive(pat[4], 4'b0010, 6);
    drive(7'b1000001, 4'b0100, 6);
    drive(pat[6], 4'b1000, 6); drive(7'b0, 4'b0, 1);
    check("illegal_blank", 32'(bcd_out), 32'h6E4F);
    check("illegal_err", 32'(digit_err), 32'h4);

    // two frames without handshake
    ready = 1'b0;
    scan(1, 2, 3, 4);
    scan(5, 6, 7, 8);
    check("ovr_data", 32'(bcd_out), 32'h5678);
    check("ovr_flag", 32'(overrun), 32'h1);
    ready = 1'b1;
    tick();
    check("ovr_clear", 32'(overrun), 32'h0);
    check("fv_clear", 32'(frame_valid), 32'h0);

    // reset after two digits accepted
    drive(pat[2], 4'b0001, 6); drive(pat[2], 4'b0010, 6);
    pulse_reset();
    drive(pat[9], 4'b0100, 6); drive(pat[9], 4'b1000, 6); drive(7'b0, 4'b0, 2);
    check("post_rst_nofv", 32'(frame_valid), 32'h0);
    scan(1, 1, 1, 1);

    // randomized runs
    for (int r = 0; r < 400; r++) begin
      logic [6:0] s;
      logic [NDIG-1:0] e;
      int c;
      ready = ($urandom_range(0, 3) != 0);
      c = $urandom_range(0, 19);
      if (c < 14) s = pat[$urandom_range(0, 9)];
      else if (c < 16) s = 7'b0;
      else s = 7'($urandom);
      e = NDIG'(1 << $urandom_range(0, NDIG - 1));
      if ($urandom_range(0, 19) == 0) e = NDIG'($urandom);
      drive(s, e, $urandom_range(1, 8));
      if ($urandom_range(0, 1) == 0) drive(7'b0, '0, $urandom_range(1, 2));
    end

`ifdef SEG7_ERRCNT_EN
    pulse_reset();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) drive(7'b1000001, NDIG'(1 << (k % NDIG)), 5);
    drive(7'b0, '0, 1);
    check("ecnt_3", 32'(err_count), 32'd3);
    for (int k = 3; k < 303; k++) drive(7'b1000001, NDIG'(1 << (k % NDIG)), 5);
    drive(7'b0, '0, 1);
    check("ecnt_sat", 32'(err_count), 32'd255);
    ready = 1'b1;
    tick();
    check("ecnt_clr", 32'(err_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg7_scan_to_bcd.md
Name: seg7_scan_to_bcd

Overview:
- Reverse of the BCD-to-7-segment path: monitors a multiplexed 7-segment display drive (segment lines plus one-hot digit enables) and recovers the BCD value of each digit.
- Used for display loop-back self-test and for scraping values from legacy display-driven peripherals.
- Filters scan glitches with a stability counter, assembles a full frame of NDIG digits, and presents it through a valid/ready handshake.

Parameters:
- NDIG, 4: number of multiplexed digits (2..8).
- STABLE_CYC, 4: consecutive identical samples required before a digit is accepted (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_en  input  NDIG  digit enables, one-hot when driving; bit0 = rightmost digit.
- bcd_out  output  4*NDIG  recovered digits; nibble i belongs to dig_en[i].
- digit_err  output  NDIG  per-digit flag: illegal segment pattern captured.
- frame_valid  output  1  bcd_out/digit_err/overrun hold a complete frame.
- frame_ready  input  1  consumer accepts the frame when high together with frame_valid.
- overrun  output  1  current frame replaced an unaccepted frame.

Behaviour:
- Reset (async assert, sync deassert by design): bcd_out=0, digit_err=0, frame_valid=0, overrun=0, all slot-seen bits=0, stability count=0, sample registers=0.
- Input stage: {seg,dig_en} registered every cycle (1-cycle sample register).
- Stability:
  - Count resets to 0 when the sample differs from the previous sample, or when dig_en is not one-hot (zero = blanking, multiple = ghosting; both ignored).
  - Count saturates at STABLE_CYC.
  - A digit is accepted once, on the edge after the same sample has been registered on STABLE_CYC consecutive edges. It is not accepted again until the sample changes.
- Decode table (seg -> nibble):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
  - 0000000 (blank) -> 4'hF, err=0.
  - Any other pattern -> 4'hE, err=1.
- Acceptance: writes the nibble and err bit into shadow slot i and sets seen[i]. Re-acceptance of a seen slot before the frame completes overwrites it (latest wins).
- FSM states:
  - COLLECT: waiting for all seen bits.
  - PRESENT: frame_valid=1.
  - Transitions:
    - COLLECT->PRESENT on the edge where the last seen bit would set. The shadow, including that digit, copies to bcd_out/digit_err, frame_valid<=1 and seen is cleared.
    - PRESENT->COLLECT when frame_valid&frame_ready: frame_valid<=0 and overrun<=0 on that edge.
    - Collection into the shadow continues in PRESENT.
- Latency: with the final digit first sampled on edge k, frame_valid rises on edge k+STABLE_CYC.
- Frame completes in PRESENT without handshake: outputs are overwritten, frame_valid stays 1, overrun<=1.
- Frame completes on the same edge as a handshake: outputs are overwritten, frame_valid stays 1, overrun<=0.
- Outputs are stable while frame_valid=1 and no new frame completes.
- Reset mid-frame discards partial slots; the first frame after reset needs all NDIG digits.

Optional Feature:
- SEG7_ERRCNT_EN defined:
  - Adds output err_count (8 bits): counts accepted digits with an illegal pattern, saturating at 255.
  - Reset to 0 by rst_n, or synchronously cleared on the edge a frame is accepted (frame_valid&frame_ready). Clear has priority over increment on the same edge.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- NDIG=4, STABLE_CYC=4; scan digits 3,0,2,9 (dig_en 0001..1000, 6 cycles each, 1 blank cycle between), frame_ready=1 -> bcd_out=16'h9203, digit_err=0, frame_valid pulses 1 cycle, 4 edges after digit3's first sample.
- Digit 1 held only 3 cycles, then 6 cycles with 7 -> slot1=7, no capture of the 3-cycle value; a 2-cycle dig_en=0011 ghost is ignored.
- seg=1000001 on digit 2 -> nibble2=4'hE, digit_err=0100; blank on digit 0 -> nibble0=4'hF, err bit 0.
- frame_ready=0 over two complete frames -> second frame data on bcd_out, frame_valid=1, overrun=1; assert frame_ready -> frame_valid and overrun cleared next edge.
- Reset asserted after 2 of 4 digits accepted -> all outputs 0 immediately; the next frame requires all 4 digits.
- With SEG7_ERRCNT_EN: 3 illegal digits, then 300 illegal digits -> err_count=3, then 255 (saturated); handshake -> 0.
